// File: rtl/count_event_logger.sv
// Watches a free-running counter's count, queues WRAP/SKIP/HOLD event words in a small FIFO
// and drains them over valid/ready; also keeps a wrap tally and a sticky drop flag.
module count_event_logger #(
   parameter int CNT_W  = 4,
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CNT_W-1:0]   count,
   input  logic               evt_ready,
   output logic               evt_valid,
   output logic [CNT_W+1:0]   evt_data,
   output logic [WRAP_W-1:0]  wrap_count,
   output logic               overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      EVT_NONE = 2'b00,
      EVT_WRAP = 2'b01,
      EVT_SKIP = 2'b10,
      EVT_HOLD = 2'b11
   } evt_type_e;

   logic [CNT_W-1:0]  prev_q, prev_d;
   logic              prev_ok_q, prev_ok_d;
   logic              hold_q, hold_d;
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W+1:0]  mem_q [DEPTH];

   evt_type_e         evt_type;
   logic [CNT_W-1:0]  prev_inc;
   logic [CNT_W+1:0]  evt_word;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push_req;
   logic              push;
   logic              pop;

   assign prev_inc = prev_q + CNT_W'(1);
   assign evt_word = {evt_type, count};

   always_comb begin
      evt_type = EVT_NONE;
      hold_d   = hold_q;
      if (prev_ok_q) begin
         if (count == prev_q) begin
            if (!hold_q) begin
               evt_type = EVT_HOLD;
            end
            hold_d = 1'b1;
         end else begin
            hold_d = 1'b0;
            // The all-ones to zero step is also prev+1, so test it before the skip rule.
            if ((prev_q == {CNT_W{1'b1}}) && (count == '0)) begin
               evt_type = EVT_WRAP;
            end else if (count != prev_inc) begin
               evt_type = EVT_SKIP;
            end
         end
      end
   end

   // Full means same slot index on both pointers but opposite lap bits.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                       (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

   assign pop      = !fifo_empty && evt_ready;
   assign push_req = (evt_type != EVT_NONE);
   assign push     = push_req && (!fifo_full || pop);

   always_comb begin
      prev_d       = count;
      prev_ok_d    = 1'b1;
      wr_ptr_d     = push ? (wr_ptr_q + (PTR_W+1)'(1)) : wr_ptr_q;
      rd_ptr_d     = pop  ? (rd_ptr_q + (PTR_W+1)'(1)) : rd_ptr_q;
      wrap_count_d = wrap_count_q;
      overflow_d   = overflow_q;
      if (evt_type == EVT_WRAP) begin
         wrap_count_d = wrap_count_q + WRAP_W'(1);
      end
      if (push_req && !push) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q       <= '0;
         prev_ok_q    <= 1'b0;
         hold_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         wrap_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         prev_ok_q    <= prev_ok_d;
         hold_q       <= hold_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         wrap_count_q <= wrap_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage needs no reset: nothing is visible until the pointers say a slot is occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= evt_word;
      end
   end

   assign evt_valid  = !fifo_empty;
   assign evt_data   = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign wrap_count = wrap_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_event_logger.sv
// Directed bench for count_event_logger: hand-computed event words, FIFO fill/drain,
// overflow, mid-stream reset, and a 256-wrap run from a reset counter model.
module tb_count_event_logger;

   logic       clk;
   logic       rst_n;
   logic [3:0] count;
   logic       evt_ready;
   logic       evt_valid;
   logic [5:0] evt_data;
   logic [7:0] wrap_count;
   logic       overflow;

   int errors;
   int checks;
   logic [5:0] got[$];

   count_event_logger #(.CNT_W(4), .DEPTH(4), .WRAP_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .count     (count),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .wrap_count(wrap_count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Words accepted by the consumer, captured mid-cycle ahead of the popping edge.
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) begin
         got.push_back(evt_data);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] c, input logic rdy);
      count     = c;
      evt_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      count     = 4'd0;
      evt_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
   endtask

   initial begin
      int wraps;
      int holds;
      int skips;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      count  = 4'd0;
      evt_ready = 1'b0;
      #12;
      $display("[TB] reset state");
      checkOutput("rst_valid", evt_valid, 0);
      checkOutput("rst_data", evt_data, 0);
      checkOutput("rst_wrap", wrap_count, 0);
      checkOutput("rst_ovf", overflow, 0);

      $display("[TB] sequential 0..15,0,1");
      doReset();
      for (int v = 0; v < 16; v++) applyStimulus(4'(v), 1'b1);
      checkOutput("seq_no_evt_before_wrap", evt_valid, 0);
      applyStimulus(4'd0, 1'b1);
      checkOutput("wrap_valid", evt_valid, 1);
      checkOutput("wrap_data", evt_data, 6'h10);
      applyStimulus(4'd1, 1'b1);
      checkOutput("seq_evt_count", got.size(), 1);
      if (got.size() > 0) checkOutput("seq_evt_word", got[0], 6'h10);
      checkOutput("seq_wrap_count", wrap_count, 1);
      checkOutput("seq_ovf", overflow, 0);
      checkOutput("seq_drained", evt_valid, 0);

      $display("[TB] skip 3,4,9,10");
      doReset();
      applyStimulus(4'd3, 1'b1);
      applyStimulus(4'd4, 1'b1);
      applyStimulus(4'd9, 1'b1);
      applyStimulus(4'd10, 1'b1);
      applyStimulus(4'd11, 1'b1);
      checkOutput("skip_evt_count", got.size(), 1);
      if (got.size() > 0) checkOutput("skip_evt_word", got[0], 6'h29);
      checkOutput("skip_wrap_count", wrap_count, 0);

      $display("[TB] hold 5 x6, 6 x4");
      doReset();
      for (int i = 0; i < 6; i++) applyStimulus(4'd5, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(4'd6, 1'b1);
      applyStimulus(4'd7, 1'b1);
      checkOutput("hold_evt_count", got.size(), 2);
      if (got.size() > 1) begin
         checkOutput("hold_evt0", got[0], 6'h35);
         checkOutput("hold_evt1", got[1], 6'h36);
      end

      $display("[TB] fill with ready low, overflow, drain");
      doReset();
      applyStimulus(4'd0, 1'b0);
      applyStimulus(4'd7, 1'b0);
      applyStimulus(4'd2, 1'b0);
      checkOutput("fill_head_stable0", evt_data, 6'h27);
      applyStimulus(4'd9, 1'b0);
      applyStimulus(4'd4, 1'b0);
      checkOutput("fill_ovf_before", overflow, 0);
      applyStimulus(4'd11, 1'b0);
      checkOutput("fill_ovf", overflow, 1);
      checkOutput("fill_valid", evt_valid, 1);
      checkOutput("fill_head_stable1", evt_data, 6'h27);
      applyStimulus(4'd12, 1'b1);
      checkOutput("drain1", evt_data, 6'h22);
      applyStimulus(4'd13, 1'b1);
      checkOutput("drain2", evt_data, 6'h29);
      applyStimulus(4'd14, 1'b1);
      checkOutput("drain3", evt_data, 6'h24);
      applyStimulus(4'd15, 1'b1);
      checkOutput("drain_empty", evt_valid, 0);
      checkOutput("drain_ovf_sticky", overflow, 1);
      checkOutput("drain_count", got.size(), 4);

      $display("[TB] push and pop on full FIFO");
      doReset();
      applyStimulus(4'd0, 1'b0);
      applyStimulus(4'd7, 1'b0);
      applyStimulus(4'd2, 1'b0);
      applyStimulus(4'd9, 1'b0);
      applyStimulus(4'd4, 1'b0);
      applyStimulus(4'd11, 1'b1);
      checkOutput("full_pp_ovf", overflow, 0);
      checkOutput("full_pp_head", evt_data, 6'h22);
      applyStimulus(4'd12, 1'b1);
      checkOutput("full_pp_d1", evt_data, 6'h29);
      applyStimulus(4'd13, 1'b1);
      checkOutput("full_pp_d2", evt_data, 6'h24);
      applyStimulus(4'd14, 1'b1);
      checkOutput("full_pp_d3", evt_data, 6'h2b);
      applyStimulus(4'd15, 1'b1);
      checkOutput("full_pp_empty", evt_valid, 0);
      checkOutput("full_pp_ovf_end", overflow, 0);

      $display("[TB] mid-stream reset pulse");
      doReset();
      applyStimulus(4'd15, 1'b0);
      applyStimulus(4'd0, 1'b0);
      applyStimulus(4'd7, 1'b0);
      checkOutput("mid_pre_valid", evt_valid, 1);
      checkOutput("mid_pre_wrap", wrap_count, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", evt_valid, 0);
      checkOutput("mid_rst_data", evt_data, 0);
      checkOutput("mid_rst_wrap", wrap_count, 0);
      checkOutput("mid_rst_ovf", overflow, 0);
      #2;
      rst_n = 1'b1;
      applyStimulus(4'd9, 1'b1);
      applyStimulus(4'd10, 1'b1);
      checkOutput("mid_post_valid", evt_valid, 0);
      checkOutput("mid_post_events", got.size(), 0);

      $display("[TB] 256 wraps from a reset counter");
      doReset();
      evt_ready = 1'b1;
      applyStimulus(4'd0, 1'b1);
      applyStimulus(4'd0, 1'b1);
      for (int w = 0; w < 256; w++) begin
         for (int v = 1; v < 16; v++) applyStimulus(4'(v), 1'b1);
         applyStimulus(4'd0, 1'b1);
         if (w == 254) checkOutput("run_wrap_255", wrap_count, 255);
      end
      applyStimulus(4'd1, 1'b1);
      applyStimulus(4'd2, 1'b1);
      wraps = 0;
      holds = 0;
      skips = 0;
      foreach (got[i]) begin
         if (got[i] == 6'h10) wraps++;
         else if (got[i] == 6'h30) holds++;
         else skips++;
      end
      checkOutput("run_wrap_count", wrap_count, 0);
      checkOutput("run_wrap_events", wraps, 256);
      checkOutput("run_hold_events", holds, 1);
      checkOutput("run_other_events", skips, 0);
      checkOutput("run_ovf", overflow, 0);
      if (got.size() > 0) checkOutput("run_first_evt", got[0], 6'h30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
